// File: rtl/encrypt_pipe_pkg.sv
// encrypt_pipe_pkg: shared types, constants and key helpers for the encrypt pipe controller.
//   ctrl_state_t    : controller states IDLE / RUN / DRAIN
//   cfg_t           : one configuration transaction (keys, rot_freq, shift_en, shift_amt, mode)
//   KEY_MOD_DEFAULT : alphabet size used for key stepping
package encrypt_pipe_pkg;

    localparam int KEY_MOD_DEFAULT = 26;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} ctrl_state_t;

    typedef struct packed {
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] k3;
        logic [2:0] rot_freq;
        logic       shift_en;
        logic       shift_amt;
        logic       mode;
    } cfg_t;

    // Keys outside the alphabet are loaded as 0.
    function automatic logic [7:0] key_sanitize(input logic [7:0] k, input int modulus);
        return (int'(k) >= modulus) ? 8'd0 : k;
    endfunction

    function automatic logic [7:0] key_inc(input logic [7:0] k, input int modulus);
        return (int'(k) >= modulus - 1) ? 8'd0 : k + 8'd1;
    endfunction

endpackage

// File: rtl/encrypt_pipe_ctrl_stepper.sv
// encrypt_key_stepper: step counter plus odometer-style k1/k2/k3 key registers.
//   clk, rst          : clock, asynchronous active-low reset
//   load_i, k*_i      : load (sanitized) initial keys and clear the step counter
//   rot_freq_i        : accepted bytes per key step, 0 disables stepping
//   adv_i             : one byte accepted this cycle
//   k1_o, k2_o, k3_o  : current keys
module encrypt_key_stepper
    import encrypt_pipe_pkg::*;
#(
    parameter int KEY_MOD = KEY_MOD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] k1_i,
    input  logic [7:0] k2_i,
    input  logic [7:0] k3_i,
    input  logic [2:0] rot_freq_i,
    input  logic       adv_i,
    output logic [7:0] k1_o,
    output logic [7:0] k2_o,
    output logic [7:0] k3_o
);

    localparam logic [7:0] KMAX = 8'(KEY_MOD - 1);

    logic [2:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] k1_q, k2_q, k3_q, k1_d, k2_d, k3_d;
    logic       adv, step, wrap1, wrap2;

    assign adv     = adv_i && rot_freq_i != 3'd0;
    assign cnt_inc = cnt_q + 3'd1;
    assign step    = adv && cnt_inc == rot_freq_i;
    // Carries ripple only through keys sitting at the top of the alphabet.
    assign wrap1   = step && k1_q == KMAX;
    assign wrap2   = wrap1 && k2_q == KMAX;

    always_comb begin
        cnt_d = load_i ? 3'd0 : adv ? (step ? 3'd0 : cnt_inc) : cnt_q;
        k1_d  = load_i ? key_sanitize(k1_i, KEY_MOD) : step  ? key_inc(k1_q, KEY_MOD) : k1_q;
        k2_d  = load_i ? key_sanitize(k2_i, KEY_MOD) : wrap1 ? key_inc(k2_q, KEY_MOD) : k2_q;
        k3_d  = load_i ? key_sanitize(k3_i, KEY_MOD) : wrap2 ? key_inc(k3_q, KEY_MOD) : k3_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 3'd0;
            k1_q  <= 8'd0;
            k2_q  <= 8'd0;
            k3_q  <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            k1_q  <= k1_d;
            k2_q  <= k2_d;
            k3_q  <= k3_d;
        end
    end

    assign k1_o = k1_q;
    assign k2_o = k2_q;
    assign k3_o = k3_q;

endmodule

// File: rtl/encrypt_pipe_ctrl.sv
// encrypt_pipe_ctrl: sequencing controller feeding the encrypt pipe's first stage.
//   clk, rst                      : clock, asynchronous active-low reset
//   cfg_valid/cfg_ready, cfg_*    : one configuration transaction per message (IDLE only)
//   s_valid/s_ready/s_data/s_last : byte stream in, paced by output-buffer credits
//   crd_ret                       : one output-buffer entry freed
//   pipe_en/pipe_din/pipe_k*      : issued byte and its keys, one cycle after accept
//   pipe_rot_freq/shift_*/mode    : latched configuration
//   busy, done, cred_err          : status; done pulses after the drain
//   ENCRYPT_PIPE_CTRL_STATS_EN    : adds stat_bytes / stat_stalls counters
module encrypt_pipe_ctrl
    import encrypt_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int CREDITS    = 8,
    parameter int KEY_MOD    = KEY_MOD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_k1,
    input  logic [7:0]  cfg_k2,
    input  logic [7:0]  cfg_k3,
    input  logic [2:0]  cfg_rot_freq,
    input  logic        cfg_shift_en,
    input  logic        cfg_shift_amt,
    input  logic        cfg_mode,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic        crd_ret,
    output logic        pipe_en,
    output logic [7:0]  pipe_din,
    output logic [7:0]  pipe_k1,
    output logic [7:0]  pipe_k2,
    output logic [7:0]  pipe_k3,
    output logic [2:0]  pipe_rot_freq,
    output logic        pipe_shift_en,
    output logic        pipe_shift_amt,
    output logic        pipe_mode,
    output logic        busy,
    output logic        done,
    output logic        cred_err
`ifdef ENCRYPT_PIPE_CTRL_STATS_EN
    ,
    output logic [15:0] stat_bytes,
    output logic [15:0] stat_stalls
`endif
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
    localparam logic [DW-1:0] DRAIN_LEN = DW'(PIPE_DEPTH);

    ctrl_state_t   state_q;
    cfg_t          cfg_in;
    logic [CW-1:0] cred_q, cred_d;
    logic [DW-1:0] drain_q;
    logic          accept, cfg_accept, cred_ovf;
    logic [7:0]    key1, key2, key3;

    assign cfg_in = '{k1: cfg_k1, k2: cfg_k2, k3: cfg_k3, rot_freq: cfg_rot_freq,
                      shift_en: cfg_shift_en, shift_amt: cfg_shift_amt, mode: cfg_mode};

    // Gated by rst so every output reads 0 while reset is held.
    assign cfg_ready  = rst && state_q == IDLE;
    assign s_ready    = state_q == RUN && cred_q != '0;
    assign busy       = state_q != IDLE;
    assign accept     = s_valid && s_ready;
    assign cfg_accept = cfg_valid && cfg_ready;
    // A return with nothing outstanding is dropped and flagged.
    assign cred_ovf   = crd_ret && !accept && cred_q == CRED_MAX;
    assign cred_d     = (accept && !crd_ret) ? cred_q - 1'b1 :
                        (crd_ret && !accept && !cred_ovf) ? cred_q + 1'b1 : cred_q;

    encrypt_key_stepper #(.KEY_MOD(KEY_MOD)) u_stepper (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cfg_accept),
        .k1_i       (cfg_in.k1),
        .k2_i       (cfg_in.k2),
        .k3_i       (cfg_in.k3),
        .rot_freq_i (pipe_rot_freq),
        .adv_i      (accept),
        .k1_o       (key1),
        .k2_o       (key2),
        .k3_o       (key3)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cred_q         <= CRED_MAX;
            drain_q        <= '0;
            pipe_en        <= 1'b0;
            pipe_din       <= 8'd0;
            pipe_k1        <= 8'd0;
            pipe_k2        <= 8'd0;
            pipe_k3        <= 8'd0;
            pipe_rot_freq  <= 3'd0;
            pipe_shift_en  <= 1'b0;
            pipe_shift_amt <= 1'b0;
            pipe_mode      <= 1'b0;
            done           <= 1'b0;
            cred_err       <= 1'b0;
        end else begin
            cred_q   <= cred_d;
            cred_err <= cred_ovf || (cred_err && !cfg_accept);
            pipe_en  <= accept;
            done     <= 1'b0;
            // Keys are captured before the stepper applies this byte's step.
            if (accept) begin
                pipe_din <= s_data;
                pipe_k1  <= key1;
                pipe_k2  <= key2;
                pipe_k3  <= key3;
            end
            case (state_q)
                IDLE: if (cfg_accept) begin
                    pipe_rot_freq  <= cfg_in.rot_freq;
                    pipe_shift_en  <= cfg_in.shift_en;
                    pipe_shift_amt <= cfg_in.shift_amt;
                    pipe_mode      <= cfg_in.mode;
                    state_q        <= RUN;
                end
                RUN: if (accept && s_last) begin
                    drain_q <= DRAIN_LEN;
                    state_q <= DRAIN;
                end
                DRAIN: if (drain_q <= DW'(1)) begin
                    drain_q <= '0;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    drain_q <= drain_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ENCRYPT_PIPE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_bytes  <= 16'd0;
            stat_stalls <= 16'd0;
        end else if (cfg_accept) begin
            stat_bytes  <= 16'd0;
            stat_stalls <= 16'd0;
        end else if (state_q == RUN) begin
            if (accept && stat_bytes != 16'hFFFF)
                stat_bytes <= stat_bytes + 16'd1;
            if (s_valid && !s_ready && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: doc/encrypt_pipe_ctrl.md
Name: encrypt_pipe_ctrl

Overview:
Sequencing controller in front of the encrypt pipeline's first (data-compare) stage.
- Accepts one configuration transaction per message, then streams message bytes into the pipe with a valid/ready handshake.
- Paces issue against credits from the downstream output buffer.
- Steps the three key registers odometer-style every rot_freq bytes.
- After the last byte, drains the pipe for a fixed depth and pulses done.

Parameters:
PIPE_DEPTH, 4, pipeline stages between pipe_en and final output; sets the drain length.
CREDITS, 8, downstream output buffer entries; initial and maximum credit count.
KEY_MOD, 26, modulus for key stepping (alphabet size).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted (IDLE only)
cfg_k1, cfg_k2, cfg_k3  in  8 each  initial keys
cfg_rot_freq  in  3  bytes per key step; 0 = no stepping
cfg_shift_en  in  1  shift cipher enable
cfg_shift_amt  in  1  shift amount select
cfg_mode  in  1  1 = encrypt active, 0 = bypass
s_valid  in  1  input byte valid
s_ready  out  1  input byte accepted
s_data  in  8  input byte
s_last  in  1  final byte of message
crd_ret  in  1  one-cycle pulse; one output-buffer entry freed
pipe_en  out  1  byte issued to the pipe
pipe_din  out  8  issued byte
pipe_k1, pipe_k2, pipe_k3  out  8 each  keys for the issued byte
pipe_rot_freq  out  3  latched rot_freq
pipe_shift_en, pipe_shift_amt, pipe_mode  out  1 each  latched config
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of drain
cred_err  out  1  sticky credit-overflow flag

Behaviour:
- Reset (async, rst=0):
  - All outputs 0; state IDLE.
  - Credit counter = CREDITS; step counter 0; drain counter 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - cfg_ready=1, s_ready=0.
  - On cfg_valid, latch all cfg_* fields, clear cred_err and the step counter, go to RUN.
  - Any key value >= KEY_MOD is loaded as 0.
- RUN:
  - s_ready = (credits != 0). A byte is accepted when s_valid && s_ready.
  - Accepted byte at cycle N appears on pipe_en=1 / pipe_din at N+1. pipe_en=0 otherwise.
  - pipe_k* carry the key values in effect before any step triggered by that byte.
  - Each accept decrements credits, and crd_ret increments them. Both in the same cycle leave credits unchanged.
  - crd_ret when credits == CREDITS (with no accept that cycle): credits hold and cred_err sets.
  - Key stepping applies when rot_freq != 0. The step counter increments per accepted byte; when it reaches rot_freq it clears and the keys step:
    - k1 = (k1+1) mod KEY_MOD.
    - If k1 wraps to 0, k2 steps the same way.
    - If k2 wraps to 0, k3 steps; k3 wraps silently.
  - Accept with s_last: go to DRAIN; the drain counter loads PIPE_DEPTH.
- DRAIN:
  - s_ready=0, cfg_ready=0.
  - The counter decrements once per cycle, starting the cycle after the last pipe_en.
  - At 0: done=1 for one cycle, go to IDLE.
  - Credits keep tracking crd_ret.
- The pipe_* config outputs hold their latched values until the next cfg accept. The keys hold their post-step value.
- Reset mid-RUN or mid-DRAIN: immediate return to the reset state, no done pulse. In-flight pipe data is discarded by the pipe's own reset.
- cfg_valid outside IDLE is ignored (cfg_ready=0).

Optional Feature:
- Macro: ENCRYPT_PIPE_CTRL_STATS_EN.
- When defined, two extra output ports:
  - stat_bytes [15:0]: accepted bytes in the current message.
  - stat_stalls [15:0]: RUN cycles with s_valid=1 and s_ready=0.
  - Both clear on cfg accept, saturate at 0xFFFF, and reset to 0.
- When undefined, the ports and counters are absent and the remaining behaviour is unchanged.

Decomposition:
- Package encrypt_pipe_pkg holds:
  - ctrl_state_t enum (IDLE, RUN, DRAIN).
  - cfg_t packed struct (k1, k2, k3, rot_freq, shift_en, shift_amt, mode).
  - KEY_MOD_DEFAULT constant.
- One natural sub-module, encrypt_key_stepper: step counter plus odometer k1/k2/k3 with a load port and a step-enable input.
- Credit counter and FSM stay in the top module.

Test Plan:
- Reset, then cfg k1=3, k2=0, k3=0, rot_freq=0, mode=1, then 3 bytes "ABC" with last on C:
  - pipe_en high 3 cycles, each one cycle after its accept; keys stay 3/0/0.
  - done pulses exactly PIPE_DEPTH cycles after the last pipe_en; busy then falls.
- cfg k1=24, k2=25, k3=7, rot_freq=1, 4 bytes:
  - pipe keys per byte: (24,25,7), (25,25,7), (0,0,8), (1,0,8).
- CREDITS=8, no crd_ret, 10 bytes offered:
  - 8 accepted, then s_ready=0.
  - One crd_ret pulse lets exactly one more byte through.
  - crd_ret coincident with an accept leaves credits unchanged.
- crd_ret pulsed in IDLE with credits=8:
  - cred_err=1 and credits stay 8.
  - Next cfg accept clears cred_err.
- Assert rst low mid-RUN after 2 of 5 bytes:
  - All outputs 0 asynchronously, credits=8, no done.
  - A fresh cfg is accepted normally.
- With ENCRYPT_PIPE_CTRL_STATS_EN, 5 bytes with 3 stall cycles at credits=0:
  - stat_bytes=5, stat_stalls=3.
